// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

    localparam int INSTR_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } loader_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles; clear has priority; hold once all-ones is reached.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: streams machine-code words into instruction memory from
// address 0, holds the core in reset while loading, releases it to run, and
// counts core cycles until the core signals done.
module prog_loader
    import loader_pkg::*;
#(
    parameter int D  = 10,
    parameter int CW = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               imem_we,
    output logic [D-1:0]       imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_reset,
    input  logic               core_done,
    output logic               busy,
    output logic               finished,
    output logic               err,
    output logic [D:0]         prog_len,
    output logic [CW-1:0]      cycles
);

    loader_state_t state;
    loader_state_t next_state;
    logic [D-1:0]  addr_cnt;

    // A new load begins from IDLE or HALT only; it clears all load results.
    logic load_start;
    // A word is taken only while loading.
    logic accept;
    // The current word lands on the last memory location.
    logic at_top;

    assign load_start = start && ((state == IDLE) || (state == HALT));
    assign accept     = (state == LOAD) && in_valid;
    assign at_top     = (addr_cnt == {D{1'b1}});

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = LOAD;
            LOAD: begin
                if (accept) begin
                    if (in_last) begin
                        next_state = RUN;
                    end else if (at_top) begin
                        next_state = IDLE;
                    end
                end
            end
            RUN:  if (core_done) next_state = HALT;
            HALT: if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Write address, program length and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt <= '0;
            prog_len <= '0;
            err      <= 1'b0;
        end else if (load_start) begin
            addr_cnt <= '0;
            prog_len <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            addr_cnt <= addr_cnt + D'(1);
            prog_len <= prog_len + (D+1)'(1);
            // A final word on the last location is a legal full-size program.
            if (!in_last && at_top) begin
                err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (CW)
    ) u_cycles (
        .clk   (clk),
        .reset (reset),
        .clear (load_start),
        .en    (state == RUN),
        .count (cycles)
    );

    // Write port presents the word on the accepting cycle; zero latency.
    assign in_ready   = (state == LOAD);
    assign imem_we    = accept;
    assign imem_addr  = addr_cnt;
    assign imem_wdata = in_data;

    // Reset is ORed in so the core is held the instant reset rises.
    assign core_reset = reset || (state != RUN);
    assign busy       = (state == LOAD) || (state == RUN);
    assign finished   = (state == HALT);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-size instance and a small one
// (D=3, CW=4) share stimulus; each test checks the instance it targets.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [8:0] in_data;
    logic       in_last;
    logic       core_done;

    // Default instance outputs
    logic        in_ready, imem_we, core_reset, busy, finished, err;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_wdata;
    logic [10:0] prog_len;
    logic [31:0] cycles;

    // Small instance outputs
    logic       s_in_ready, s_imem_we, s_core_reset, s_busy, s_finished, s_err;
    logic [2:0] s_imem_addr;
    logic [8:0] s_imem_wdata;
    logic [3:0] s_prog_len;
    logic [3:0] s_cycles;

    int n_pass = 0;
    int n_total = 0;

    // Write logs (monotonic, written only by the monitors)
    int wr_total = 0;
    int log_addr [256];
    int log_data [256];
    int s_wr_total = 0;
    int s_log_addr [256];
    int s_release_cnt = 0;

    always #5 clk = ~clk;

    prog_loader #(.D(10), .CW(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .core_done(core_done), .busy(busy),
        .finished(finished), .err(err), .prog_len(prog_len), .cycles(cycles)
    );

    prog_loader #(.D(3), .CW(4)) u_small (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(s_in_ready),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .core_reset(s_core_reset), .core_done(core_done), .busy(s_busy),
        .finished(s_finished), .err(s_err), .prog_len(s_prog_len), .cycles(s_cycles)
    );

    // Inputs change 1 time unit after posedge, so negedge sees a settled write port.
    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_total < 256) begin
                log_addr[wr_total] = int'(imem_addr);
                log_data[wr_total] = int'(imem_wdata);
            end
            wr_total = wr_total + 1;
        end
        if (s_imem_we) begin
            if (s_wr_total < 256) s_log_addr[s_wr_total] = int'(s_imem_addr);
            s_wr_total = s_wr_total + 1;
        end
        if (!s_core_reset) s_release_cnt = s_release_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; in_valid = 1'b0; in_data = 9'h000; in_last = 1'b0; core_done = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word for one cycle; a word offered while not ready is a failure.
    task automatic send_word(input logic [8:0] data, input logic last);
        in_valid = 1'b1; in_data = data; in_last = last;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        else n_pass++;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        in_valid = 1'b1;
        #3;
        n_total++; if (core_reset !== 1'b1) $display("FAIL rst_core_reset: %b required 1", core_reset); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: %b required 0", in_ready); else n_pass++;
        n_total++; if (imem_we !== 1'b0) $display("FAIL rst_imem_we: %b required 0", imem_we); else n_pass++;
        n_total++; if (busy !== 1'b0 || finished !== 1'b0) $display("FAIL rst_busy_fin: %b%b required 00", busy, finished); else n_pass++;
        n_total++; if (imem_addr !== 10'd0) $display("FAIL rst_addr: %0d required 0", imem_addr); else n_pass++;
        n_total++; if (prog_len !== 11'd0 || cycles !== 32'd0 || err !== 1'b0)
            $display("FAIL rst_regs: len=%0d cyc=%0d err=%b required 0/0/0", prog_len, cycles, err); else n_pass++;
        do_reset();
        // core_done and in_valid are ignored in IDLE
        core_done = 1'b1; in_valid = 1'b1;
        tick(); tick();
        n_total++; if (finished !== 1'b0 || busy !== 1'b0 || cycles !== 32'd0)
            $display("FAIL idle_ignore: fin=%b busy=%b cyc=%0d required 0/0/0", finished, busy, cycles); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_load_run();
        int base;
        logic [8:0] words [4];
        words[0] = 9'h001; words[1] = 9'h002; words[2] = 9'h003; words[3] = 9'h1FF;
        do_reset();
        do_start();
        #1;
        n_total++; if (in_ready !== 1'b1 || busy !== 1'b1) $display("FAIL load_enter: rdy=%b busy=%b required 1/1", in_ready, busy); else n_pass++;
        base = wr_total;
        for (int i = 0; i < 4; i++) send_word(words[i], i == 3);
        n_total++; if (wr_total - base !== 4) $display("FAIL b2b_count: %0d writes required 4", wr_total - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (log_addr[base+i] !== i || log_data[base+i] !== int'(words[i]))
                $display("FAIL b2b_write%0d: addr=%0d data=%0h required %0d/%0h", i, log_addr[base+i], log_data[base+i], i, words[i]);
            else n_pass++;
        end
        n_total++; if (prog_len !== 11'd4) $display("FAIL b2b_len: %0d required 4", prog_len); else n_pass++;
        n_total++; if (core_reset !== 1'b0 || cycles !== 32'd0) $display("FAIL run_enter: crst=%b cyc=%0d required 0/0", core_reset, cycles); else n_pass++;
        repeat (6) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        n_total++; if (cycles !== 32'd7) $display("FAIL run_cycles: %0d required 7", cycles); else n_pass++;
        n_total++; if (finished !== 1'b1 || core_reset !== 1'b1 || busy !== 1'b0)
            $display("FAIL halt: fin=%b crst=%b busy=%b required 1/1/0", finished, core_reset, busy); else n_pass++;
        tick();
        n_total++; if (cycles !== 32'd7 || prog_len !== 11'd4) $display("FAIL halt_hold: cyc=%0d len=%0d required 7/4", cycles, prog_len); else n_pass++;
    endtask

    task automatic test_gapped();
        int base;
        int k;
        logic [8:0] words [4];
        words[0] = 9'h001; words[1] = 9'h002; words[2] = 9'h003; words[3] = 9'h1FF;
        do_reset();
        do_start();
        base = wr_total;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) begin
                in_valid = 1'b1; in_data = words[k]; in_last = (k == 3);
                k++;
            end else begin
                in_valid = 1'b0; in_data = 9'h155; in_last = 1'b0;
                #1;
                n_total++; if (imem_we !== 1'b0) $display("FAIL gap_we%0d: %b required 0", c, imem_we); else n_pass++;
            end
            tick();
        end
        idle_inputs();
        n_total++; if (wr_total - base !== 4) $display("FAIL gap_count: %0d writes required 4", wr_total - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (log_addr[base+i] !== i || log_data[base+i] !== int'(words[i]))
                $display("FAIL gap_write%0d: addr=%0d data=%0h required %0d/%0h", i, log_addr[base+i], log_data[base+i], i, words[i]);
            else n_pass++;
        end
        n_total++; if (prog_len !== 11'd4 || core_reset !== 1'b0) $display("FAIL gap_run: len=%0d crst=%b required 4/0", prog_len, core_reset); else n_pass++;
    endtask

    task automatic test_overflow();
        int base;
        int rel_base;
        do_reset();
        do_start();
        base = s_wr_total;
        rel_base = s_release_cnt;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 9'(9'h10 + i); in_last = 1'b0;
            #1;
            n_total++; if (s_in_ready !== 1'b1) $display("FAIL ovf_ready%0d: %b required 1", i, s_in_ready); else n_pass++;
            tick();
        end
        idle_inputs();
        #1;
        n_total++; if (s_wr_total - base !== 8) $display("FAIL ovf_count: %0d writes required 8", s_wr_total - base); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (s_log_addr[base+i] !== i) $display("FAIL ovf_addr%0d: %0d required %0d", i, s_log_addr[base+i], i); else n_pass++;
        end
        n_total++; if (s_err !== 1'b1 || s_busy !== 1'b0 || s_finished !== 1'b0 || s_in_ready !== 1'b0)
            $display("FAIL ovf_state: err=%b busy=%b fin=%b rdy=%b required 1/0/0/0", s_err, s_busy, s_finished, s_in_ready); else n_pass++;
        tick(); tick();
        n_total++; if (s_release_cnt - rel_base !== 0 || s_core_reset !== 1'b1)
            $display("FAIL ovf_release: released %0d cycles crst=%b required 0/1", s_release_cnt - rel_base, s_core_reset); else n_pass++;
        // start from IDLE clears err; a full 8-word program with in_last on the top word runs
        do_start();
        n_total++; if (s_err !== 1'b0 || s_prog_len !== 4'd0 || s_in_ready !== 1'b1)
            $display("FAIL ovf_restart: err=%b len=%0d rdy=%b required 0/0/1", s_err, s_prog_len, s_in_ready); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 9'(i); in_last = (i == 7);
            tick();
        end
        idle_inputs();
        #1;
        n_total++; if (s_err !== 1'b0 || s_core_reset !== 1'b0 || s_prog_len !== 4'd8 || s_busy !== 1'b1)
            $display("FAIL last_wins: err=%b crst=%b len=%0d busy=%b required 0/0/8/1", s_err, s_core_reset, s_prog_len, s_busy); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        do_start();
        send_word(9'h0AA, 1'b1);
        repeat (4) tick();
        n_total++; if (cycles !== 32'd4 || core_reset !== 1'b0) $display("FAIL mid_pre: cyc=%0d crst=%b required 4/0", cycles, core_reset); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (core_reset !== 1'b1) $display("FAIL mid_core_reset: %b required 1 before edge", core_reset); else n_pass++;
        n_total++; if (cycles !== 32'd0 || busy !== 1'b0 || finished !== 1'b0 || prog_len !== 11'd0)
            $display("FAIL mid_regs: cyc=%0d busy=%b fin=%b len=%0d required 0/0/0/0", cycles, busy, finished, prog_len); else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        n_total++; if (busy !== 1'b0 || core_reset !== 1'b1) $display("FAIL mid_idle: busy=%b crst=%b required 0/1", busy, core_reset); else n_pass++;
    endtask

    task automatic test_start_run_halt();
        do_reset();
        do_start();
        send_word(9'h011, 1'b0);
        send_word(9'h022, 1'b1);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        n_total++; if (busy !== 1'b1 || core_reset !== 1'b0 || cycles !== 32'd3 || prog_len !== 11'd2)
            $display("FAIL run_start: busy=%b crst=%b cyc=%0d len=%0d required 1/0/3/2", busy, core_reset, cycles, prog_len); else n_pass++;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        n_total++; if (finished !== 1'b1 || cycles !== 32'd4) $display("FAIL run_halt: fin=%b cyc=%0d required 1/4", finished, cycles); else n_pass++;
        do_start();
        n_total++; if (cycles !== 32'd0 || finished !== 1'b0 || err !== 1'b0 || prog_len !== 11'd0 || in_ready !== 1'b1)
            $display("FAIL halt_start: cyc=%0d fin=%b err=%b len=%0d rdy=%b required 0/0/0/0/1", cycles, finished, err, prog_len, in_ready); else n_pass++;
        in_valid = 1'b1; in_data = 9'h0AA; in_last = 1'b0;
        #1;
        n_total++; if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 9'h0AA)
            $display("FAIL halt_reload: we=%b addr=%0d data=%0h required 1/0/0aa", imem_we, imem_addr, imem_wdata); else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_saturate();
        do_reset();
        do_start();
        send_word(9'h001, 1'b1);
        repeat (15) tick();
        n_total++; if (s_cycles !== 4'd15) $display("FAIL sat_reach: %0d required 15", s_cycles); else n_pass++;
        repeat (5) tick();
        n_total++; if (s_cycles !== 4'd15 || s_finished !== 1'b0) $display("FAIL sat_hold: cyc=%0d fin=%b required 15/0", s_cycles, s_finished); else n_pass++;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        n_total++; if (s_finished !== 1'b1 || s_cycles !== 4'd15) $display("FAIL sat_halt: fin=%b cyc=%0d required 1/15", s_finished, s_cycles); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_gapped();
        test_overflow();
        test_reset_mid_run();
        test_start_run_halt();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
